// File: rtl/pg_row_feeder.sv
// rtl/pg_row_feeder.sv - row split and propagate/generate front end for the 22-bit product carry chain, two-entry skid buffered
// Optional build macro PGF_EXACT_LOW_EN selects an exact low-part sum instead of the approximate OR.
module pg_row_feeder #(
    parameter int LOW_W = 10,
    parameter int ROW_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ROW_W-1:0]       row_a,
    input  logic [ROW_W-1:0]       row_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ROW_W-LOW_W-1:0] prop,
    output logic [ROW_W-LOW_W-1:0] gen,
    output logic                   cin,
    output logic [LOW_W-1:0]       low_product,
    output logic [15:0]            beat_count
);
    localparam int CH_W = ROW_W - LOW_W;
    localparam int PW   = 2 * CH_W + 1 + LOW_W;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t            state, state_n;
    logic [PW-1:0]     main_q, skid_q, in_word;
    logic              main_valid_q, skid_valid_q, in_ready_q;
    logic [15:0]       beat_q;
    logic              accept, consume;
    logic              load_main, load_skid, skid_to_main;
    logic [CH_W-1:0]   in_prop, in_gen;
    logic              in_cin;
    logic [LOW_W-1:0]  in_low;

    assign in_prop = row_a[ROW_W-1:LOW_W] ^ row_b[ROW_W-1:LOW_W];
    assign in_gen  = row_a[ROW_W-1:LOW_W] & row_b[ROW_W-1:LOW_W];

`ifdef PGF_EXACT_LOW_EN
    assign {in_cin, in_low} = {1'b0, row_a[LOW_W-1:0]} + {1'b0, row_b[LOW_W-1:0]};
`else
    // Approximate low part: the MSB pair alone decides the carry into the chain.
    assign in_low = row_a[LOW_W-1:0] | row_b[LOW_W-1:0];
    assign in_cin = row_a[LOW_W-1] & row_b[LOW_W-1];
`endif

    assign in_word = {in_prop, in_gen, in_cin, in_low};

    assign accept  = in_valid & in_ready_q;
    assign consume = main_valid_q & out_ready;

    always_comb begin
        state_n      = state;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_main = 1'b1;
                    state_n   = ONE;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_n   = FULL;
                end else if (consume) begin
                    state_n = EMPTY;
                end
            end
            FULL: begin
                if (consume && skid_valid_q) begin
                    skid_to_main = 1'b1;
                    state_n      = ONE;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    // in_ready is derived from the next state so it never depends combinationally on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= EMPTY;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            main_q       <= '0;
            skid_q       <= '0;
            beat_q       <= '0;
        end else begin
            state        <= state_n;
            main_valid_q <= (state_n != EMPTY);
            skid_valid_q <= (state_n == FULL);
            in_ready_q   <= (state_n != FULL);
            if (load_main)
                main_q <= in_word;
            else if (skid_to_main)
                main_q <= skid_q;
            if (load_skid)
                skid_q <= in_word;
            if (consume)
                beat_q <= beat_q + 16'd1;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = main_valid_q;
    assign {prop, gen, cin, low_product} = main_q;
    assign beat_count = beat_q;

endmodule
